// File: rtl/id_operand_unit.sv
// Decode-stage operand unit: register file, prioritised forwarding, pending-write scoreboard, signed comparator.
// Optional write trace enabled by defining ID_TRACE_EN.
module id_operand_unit #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned NREG         = 32,
  parameter int unsigned NRD          = 2,
  parameter int unsigned NFWD         = 3,
  parameter int unsigned MAX_INFLIGHT = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NRD*$clog2(NREG)-1:0]   rd_addr,
  input  logic [NRD-1:0]                rd_used,
  output logic [NRD*XLEN-1:0]           rd_data,
  input  logic                          issue_valid,
  input  logic [$clog2(NREG)-1:0]       issue_dst,
  input  logic                          wb_we,
  input  logic [$clog2(NREG)-1:0]       wb_addr,
  input  logic [XLEN-1:0]               wb_data,
  input  logic [31:0]                   wb_pc,
  input  logic [NFWD-1:0]               fwd_valid,
  input  logic [NFWD*$clog2(NREG)-1:0]  fwd_addr,
  input  logic [NFWD*XLEN-1:0]          fwd_data,
  output logic                          stall,
  output logic                          cmp_eq,
  output logic                          cmp_gt,
  output logic                          cmp_lt,
  output logic                          sb_error
);

  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1);

  logic [XLEN-1:0] regs [NREG];
  logic [CW-1:0]   pend [NREG];
  logic [AW-1:0]   port_addr [NRD];
  logic [XLEN-1:0] port_data [NRD];
  logic [NRD-1:0]  port_hit;
  logic [NREG-1:0] inc_hit;
  logic [NREG-1:0] dec_hit;
  logic            inc;
  logic            dec;
  logic [XLEN-1:0] op0;
  logic [XLEN-1:0] op1;

  // Operand resolution (youngest forward wins, then writeback bypass, then array) and RAW stall.
  always_comb begin
    rd_data  = '0;
    stall    = 1'b0;
    port_hit = '0;
    for (int i = 0; i < int'(NRD); i++) begin
      port_addr[i] = rd_addr[i*AW +: AW];
      port_data[i] = regs[port_addr[i]];
      if (wb_we && wb_addr == port_addr[i]) begin
        port_data[i] = wb_data;
        port_hit[i]  = 1'b1;
      end
      for (int j = int'(NFWD) - 1; j >= 0; j--) begin
        if (fwd_valid[j] && fwd_addr[j*AW +: AW] == port_addr[i]) begin
          port_data[i] = fwd_data[j*XLEN +: XLEN];
          port_hit[i]  = 1'b1;
        end
      end
      if (port_addr[i] == '0) begin
        port_data[i] = '0;
      end
      rd_data[i*XLEN +: XLEN] = port_data[i];
      if (rd_used[i] && port_addr[i] != '0) begin
        if (int'(pend[port_addr[i]]) >= 2 ||
            (int'(pend[port_addr[i]]) == 1 && !port_hit[i])) begin
          stall = 1'b1;
        end
      end
    end
  end

  assign op0    = rd_data[0 +: XLEN];
  assign op1    = rd_data[XLEN +: XLEN];
  assign cmp_eq = (op0 == op1);
  assign cmp_lt = ($signed(op0) < $signed(op1));
  assign cmp_gt = !cmp_eq && !cmp_lt;

  assign inc = issue_valid && !stall && issue_dst != '0;
  assign dec = wb_we && wb_addr != '0;

  always_comb begin
    inc_hit = '0;
    dec_hit = '0;
    for (int r = 0; r < int'(NREG); r++) begin
      inc_hit[r] = inc && issue_dst == AW'(r);
      dec_hit[r] = dec && wb_addr == AW'(r);
    end
  end

  // Register array and saturating pending-writer counters; a matched inc/dec pair cancels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < int'(NREG); r++) begin
        regs[r] <= '0;
        pend[r] <= '0;
      end
      sb_error <= 1'b0;
    end else begin
      if (dec) begin
        regs[wb_addr] <= wb_data;
      end
      for (int r = 0; r < int'(NREG); r++) begin
        if (inc_hit[r] && !dec_hit[r]) begin
          if (pend[r] == CW'(MAX_INFLIGHT)) sb_error <= 1'b1;
          else                              pend[r]  <= pend[r] + CW'(1);
        end else if (dec_hit[r] && !inc_hit[r]) begin
          if (pend[r] == '0) sb_error <= 1'b1;
          else               pend[r]  <= pend[r] - CW'(1);
        end
      end
    end
  end

`ifdef ID_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && dec) begin
      $display("@%h: $%d <= %h", wb_pc, wb_addr, wb_data);
    end
  end
`else
  logic trace_unused;
  assign trace_unused = ^wb_pc;
`endif

endmodule

// File: tb/tb_id_operand_unit.sv
// Directed, table-driven bench for id_operand_unit with hand sequences for scoreboard corners.
module tb_id_operand_unit;

  localparam logic [2:0] EQ = 3'b100;
  localparam logic [2:0] GT = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [1:0]  rd_used;
  logic [63:0] rd_data;
  logic        issue_valid;
  logic [4:0]  issue_dst;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic [2:0]  fwd_valid;
  logic [14:0] fwd_addr;
  logic [95:0] fwd_data;
  logic        stall, cmp_eq, cmp_gt, cmp_lt, sb_error;

  id_operand_unit dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_used(rd_used), .rd_data(rd_data),
    .issue_valid(issue_valid), .issue_dst(issue_dst), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_pc(wb_pc), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .stall(stall), .cmp_eq(cmp_eq), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt),
    .sb_error(sb_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a0, a1;
    logic [1:0]  used;
    logic [2:0]  fv;
    logic [4:0]  fa0, fa1, fa2;
    logic [31:0] fd0, fd1, fd2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iv;
    logic [4:0]  id;
    logic [31:0] e0, e1;
    logic        es;
    logic [2:0]  ecmp;
    logic        eerr;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rd_addr     = {t.a1, t.a0};
    rd_used     = t.used;
    fwd_valid   = t.fv;
    fwd_addr    = {t.fa2, t.fa1, t.fa0};
    fwd_data    = {t.fd2, t.fd1, t.fd0};
    wb_we       = t.we;
    wb_addr     = t.wa;
    wb_data     = t.wd;
    wb_pc       = 32'h0000_1000 + {27'd0, t.wa};
    issue_valid = t.iv;
    issue_dst   = t.id;
  endtask

  // Drive at the falling edge; outputs sampled 1 ns later, well before the rising edge.
  task automatic step(input vec_t t);
    @(negedge clk);
    drive(t);
    #1;
  endtask

  function automatic vec_t mk(input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] used,
                              input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic iv, input logic [4:0] id);
    vec_t t;
    t = '{a0, a1, used, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0,
          we, wa, wd, iv, id, 32'd0, 32'd0, 1'b0, EQ, 1'b0};
    return t;
  endfunction

  initial begin
    //         a0  a1  used   fv      fa0 fa1 fa2 fd0           fd1     fd2    we wa  wd        iv id   e0            e1            es  cmp eerr
    vecs[0]  = '{5,  6,  2'b11, 3'b000, 0,  0,  0,  0,            0,      0,     0, 0,  0,        0, 0,  0,            0,            0,  EQ, 0};
    vecs[1]  = '{1,  2,  2'b00, 3'b000, 0,  0,  0,  0,            0,      0,     0, 0,  0,        1, 3,  0,            0,            0,  EQ, 0};
    vecs[2]  = '{3,  0,  2'b01, 3'b000, 0,  0,  0,  0,            0,      0,     1, 3,  32'h1234, 0, 0,  32'h1234,     0,            0,  GT, 0};
    vecs[3]  = '{3,  3,  2'b11, 3'b000, 0,  0,  0,  0,            0,      0,     0, 0,  0,        0, 0,  32'h1234,     32'h1234,     0,  EQ, 0};
    vecs[4]  = '{3,  0,  2'b00, 3'b000, 0,  0,  0,  0,            0,      0,     0, 0,  0,        1, 4,  32'h1234,     0,            0,  GT, 0};
    vecs[5]  = '{4,  3,  2'b11, 3'b000, 0,  0,  0,  0,            0,      0,     0, 0,  0,        0, 0,  0,            32'h1234,     1,  LT, 0};
    vecs[6]  = '{4,  3,  2'b11, 3'b010, 0,  4,  0,  0,            32'hAA, 0,     0, 0,  0,        0, 0,  32'hAA,       32'h1234,     0,  LT, 0};
    vecs[7]  = '{4,  4,  2'b11, 3'b000, 0,  0,  0,  0,            0,      0,     1, 4,  32'hAA,   0, 0,  32'hAA,       32'hAA,       0,  EQ, 0};
    vecs[8]  = '{7,  0,  2'b11, 3'b111, 7,  0,  7,  1,            32'hFF, 2,     0, 0,  0,        0, 0,  1,            0,            0,  GT, 0};
    vecs[9]  = '{7,  8,  2'b11, 3'b011, 7,  8,  0,  32'hFFFFFFFF, 1,      0,     0, 0,  0,        0, 0,  32'hFFFFFFFF, 1,            0,  LT, 0};
    vecs[10] = '{8,  7,  2'b11, 3'b011, 7,  8,  0,  32'hFFFFFFFF, 1,      0,     0, 0,  0,        0, 0,  1,            32'hFFFFFFFF, 0,  GT, 0};
    vecs[11] = '{0,  0,  2'b00, 3'b000, 0,  0,  0,  0,            0,      0,     0, 0,  0,        1, 10, 0,            0,            0,  EQ, 0};
    vecs[12] = '{10, 0,  2'b00, 3'b000, 0,  0,  0,  0,            0,      0,     0, 0,  0,        1, 10, 0,            0,            0,  EQ, 0};
    vecs[13] = '{10, 0,  2'b01, 3'b001, 10, 0,  0,  32'h55,       0,      0,     0, 0,  0,        0, 0,  32'h55,       0,            1,  GT, 0};
    vecs[14] = '{10, 0,  2'b01, 3'b010, 0,  10, 0,  0,            32'h66, 0,     1, 10, 32'h55,   0, 0,  32'h66,       0,            1,  GT, 0};
    vecs[15] = '{10, 0,  2'b01, 3'b000, 0,  0,  0,  0,            0,      0,     1, 10, 32'h66,   0, 0,  32'h66,       0,            0,  GT, 0};
    vecs[16] = '{0,  0,  2'b00, 3'b000, 0,  0,  0,  0,            0,      0,     0, 0,  0,        1, 12, 0,            0,            0,  EQ, 0};
    vecs[17] = '{12, 0,  2'b01, 3'b000, 0,  0,  0,  0,            0,      0,     0, 0,  0,        1, 13, 0,            0,            1,  EQ, 0};
    vecs[18] = '{13, 12, 2'b11, 3'b000, 0,  0,  0,  0,            0,      0,     1, 12, 32'h77,   0, 0,  0,            32'h77,       0,  LT, 0};
    vecs[19] = '{12, 13, 2'b11, 3'b000, 0,  0,  0,  0,            0,      0,     0, 0,  0,        0, 0,  32'h77,       0,            0,  GT, 0};

    reset = 1'b1;
    drive(mk(5, 6, 2'b11, 0, 0, 0, 0, 0));
    #2;
    check("reset.sb_error", {31'd0, sb_error}, 32'd0);
    check("reset.stall", {31'd0, stall}, 32'd0);
    check("reset.cmp", {29'd0, cmp_eq, cmp_gt, cmp_lt}, {29'd0, EQ});
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < NV; k++) begin
      step(vecs[k]);
      check($sformatf("v%0d.d0", k), rd_data[31:0], vecs[k].e0);
      check($sformatf("v%0d.d1", k), rd_data[63:32], vecs[k].e1);
      check($sformatf("v%0d.stall", k), {31'd0, stall}, {31'd0, vecs[k].es});
      check($sformatf("v%0d.cmp", k), {29'd0, cmp_eq, cmp_gt, cmp_lt}, {29'd0, vecs[k].ecmp});
      check($sformatf("v%0d.sb_error", k), {31'd0, sb_error}, {31'd0, vecs[k].eerr});
    end

    // Same-cycle issue and writeback to r15 leaves one writer pending.
    step(mk(0, 0, 2'b00, 0, 0, 0, 1, 15));
    step(mk(15, 0, 2'b01, 1, 15, 32'h9, 1, 15));
    check("incdec.stall", {31'd0, stall}, 32'd0);
    step(mk(15, 0, 2'b01, 0, 0, 0, 0, 0));
    check("incdec.pending_stall", {31'd0, stall}, 32'd1);
    step(mk(15, 0, 2'b01, 1, 15, 32'h9, 0, 0));
    check("incdec.wb_release", {31'd0, stall}, 32'd0);
    step(mk(15, 0, 2'b01, 0, 0, 0, 0, 0));
    check("incdec.clear_stall", {31'd0, stall}, 32'd0);
    check("incdec.data", rd_data[31:0], 32'h9);
    check("incdec.sb_error", {31'd0, sb_error}, 32'd0);

    // Write to r0 is ignored and does not touch the scoreboard.
    step(mk(0, 0, 2'b11, 1, 0, 32'hDEAD, 0, 0));
    check("r0wb.bypass", rd_data[31:0], 32'd0);
    step(mk(0, 0, 2'b11, 0, 0, 0, 0, 0));
    check("r0wb.data", rd_data[31:0], 32'd0);
    check("r0wb.sb_error", {31'd0, sb_error}, 32'd0);

    // Saturation: three writers fit, the fourth overflows.
    for (int n = 0; n < 3; n++) step(mk(0, 0, 2'b00, 0, 0, 0, 1, 9));
    step(mk(9, 0, 2'b01, 0, 0, 0, 0, 0));
    check("sat.full_no_error", {31'd0, sb_error}, 32'd0);
    check("sat.stall", {31'd0, stall}, 32'd1);
    step(mk(0, 0, 2'b00, 0, 0, 0, 1, 9));
    step(mk(0, 0, 2'b00, 0, 0, 0, 0, 0));
    check("sat.sb_error", {31'd0, sb_error}, 32'd1);

    // Asynchronous reset mid-run clears array, scoreboard and error flag.
    step(mk(3, 9, 2'b11, 0, 0, 0, 0, 0));
    reset = 1'b1;
    #1;
    check("rst.sb_error", {31'd0, sb_error}, 32'd0);
    check("rst.r3", rd_data[31:0], 32'd0);
    check("rst.stall", {31'd0, stall}, 32'd0);
    check("rst.cmp", {29'd0, cmp_eq, cmp_gt, cmp_lt}, {29'd0, EQ});
    @(negedge clk);
    reset = 1'b0;

    // Underflow: writeback with no pending writer.
    step(mk(20, 0, 2'b01, 1, 20, 32'h5, 0, 0));
    check("uflow.bypass", rd_data[31:0], 32'h5);
    step(mk(20, 0, 2'b01, 0, 0, 0, 0, 0));
    check("uflow.sb_error", {31'd0, sb_error}, 32'd1);
    check("uflow.data", rd_data[31:0], 32'h5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
